// File: rtl/adder_arbiter_if.sv
// Request/response bundle between ALU-side clients and the shared adder arbiter.
// Requester i owns bits [32i+31:32i] of req_a/req_b and bit i of the per-requester vectors.
interface adder_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = (N_REQ > 2) ? $clog2(N_REQ) : 1
);
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ*32-1:0] req_a;
    logic [N_REQ*32-1:0] req_b;
    logic [N_REQ-1:0]    req_cin;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [ID_W-1:0]     rsp_id;
    logic [31:0]         rsp_sum;
    logic                rsp_cout;

    modport master (
        output req_valid, req_a, req_b, req_cin, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
    );

    modport slave (
        input  req_valid, req_a, req_b, req_cin, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
    );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one 32-bit carry-lookahead adder between N_REQ requesters,
// with a single registered response slot that can drain and refill on the same edge.
module adder_arbiter #(
    parameter int N_REQ = 4
) (
    input logic           clk,
    input logic           rst,
    adder_arbiter_if.slave bus
);
    localparam int WIDTH = 32;
    localparam int ID_W  = (N_REQ > 2) ? $clog2(N_REQ) : 1;
    localparam int CW    = ID_W + 1;

    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  grant;
    logic             found;
    logic [CW-1:0]    cand;
    logic             can_issue;
    logic             accept;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_cin;
    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] prop;
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;

    assign can_issue = !bus.rsp_valid || bus.rsp_ready;

    // First valid requester scanning upward from ptr, wrapping modulo N_REQ.
    always_comb begin
        found = 1'b0;
        grant = '0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr} + CW'(k);
            if (cand >= CW'(N_REQ)) begin
                cand = cand - CW'(N_REQ);
            end
            if (!found && bus.req_valid[cand[ID_W-1:0]]) begin
                found = 1'b1;
                grant = cand[ID_W-1:0];
            end
        end
    end

    // Ready is suppressed during reset so a requester never sees a handshake that is dropped.
    assign accept = found && can_issue && !rst;

    always_comb begin
        bus.req_ready = '0;
        if (accept) begin
            bus.req_ready[grant] = 1'b1;
        end
    end

    always_comb begin
        op_a   = '0;
        op_b   = '0;
        op_cin = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant == ID_W'(i)) begin
                op_a   = bus.req_a[i*WIDTH +: WIDTH];
                op_b   = bus.req_b[i*WIDTH +: WIDTH];
                op_cin = bus.req_cin[i];
            end
        end
    end

    // 4-bit lookahead groups; the group carry-out feeds the next group's carry-in.
    always_comb begin
        gen      = op_a & op_b;
        prop     = op_a ^ op_b;
        carry    = '0;
        carry[0] = op_cin;
        for (int b = 0; b < WIDTH; b += 4) begin
            carry[b+1] = gen[b] | (prop[b] & carry[b]);
            carry[b+2] = gen[b+1] | (prop[b+1] & gen[b])
                       | (prop[b+1] & prop[b] & carry[b]);
            carry[b+3] = gen[b+2] | (prop[b+2] & gen[b+1])
                       | (prop[b+2] & prop[b+1] & gen[b])
                       | (prop[b+2] & prop[b+1] & prop[b] & carry[b]);
            carry[b+4] = gen[b+3] | (prop[b+3] & gen[b+2])
                       | (prop[b+3] & prop[b+2] & gen[b+1])
                       | (prop[b+3] & prop[b+2] & prop[b+1] & gen[b])
                       | (prop[b+3] & prop[b+2] & prop[b+1] & prop[b] & carry[b]);
        end
        sum = prop ^ carry[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr          <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_sum   <= '0;
            bus.rsp_cout  <= 1'b0;
        end else if (accept) begin
            ptr           <= (grant == ID_W'(N_REQ - 1)) ? '0 : grant + ID_W'(1);
            bus.rsp_valid <= 1'b1;
            bus.rsp_id    <= grant;
            bus.rsp_sum   <= sum;
            bus.rsp_cout  <= carry[WIDTH];
        end else if (bus.rsp_valid && bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter: the stimulus side predicts grants and sums,
// an independent monitor pops and compares every response the DUT hands over.
module tb_adder_arbiter;
    localparam int N = 4;

    typedef struct {
        int          id;
        logic [31:0] sum;
        logic        cout;
    } rsp_t;

    logic clk = 1'b0;
    logic rst;
    rsp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   model_ptr = 0;
    bit   model_full = 1'b0;

    adder_arbiter_if #(.N_REQ(N)) bus ();

    adder_arbiter #(.N_REQ(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int model_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 3))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'h0000_0000;
            default: return $urandom();
        endcase
    endfunction

    task automatic applyStimulus(input int i, input logic [31:0] a, input logic [31:0] b,
                                 input logic cin);
        bus.req_a[32*i +: 32] = a;
        bus.req_b[32*i +: 32] = b;
        bus.req_cin[i]        = cin;
        bus.req_valid[i]      = 1'b1;
    endtask

    task automatic checkOutput(input string name, input logic v, input int id,
                               input logic [31:0] sum, input logic cout);
        check({name, "_valid"}, 64'(bus.rsp_valid), 64'(v));
        check({name, "_id"},    64'(bus.rsp_id),    64'(id));
        check({name, "_sum"},   64'(bus.rsp_sum),   64'(sum));
        check({name, "_cout"},  64'(bus.rsp_cout),  64'(cout));
    endtask

    // One clock: predict the grant at the negedge, then retire the accepted request after the edge.
    task automatic tick(output int granted);
        logic [N-1:0] exp_ready;
        logic [32:0]  full;
        int           g;
        rsp_t         r;
        @(negedge clk);
        g = -1;
        exp_ready = '0;
        if (!rst && (!model_full || bus.rsp_ready)) g = model_pick(bus.req_valid, model_ptr);
        if (g >= 0) exp_ready[g] = 1'b1;
        check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
        check("rsp_valid_state", 64'(bus.rsp_valid), 64'(model_full));
        if (rst) begin
            model_ptr  = 0;
            model_full = 1'b0;
            exp_q.delete();
        end else if (g >= 0) begin
            full = {1'b0, bus.req_a[32*g +: 32]} + {1'b0, bus.req_b[32*g +: 32]}
                 + 33'(bus.req_cin[g]);
            r.id   = g;
            r.sum  = full[31:0];
            r.cout = full[32];
            exp_q.push_back(r);
            model_ptr  = (g + 1) % N;
            model_full = 1'b1;
        end else if (bus.rsp_ready) begin
            model_full = 1'b0;
        end
        granted = g;
        @(posedge clk);
        #1;
        if (g >= 0) bus.req_valid[g] = 1'b0;
    endtask

    task automatic do_reset();
        int g;
        rst = 1'b1;
        tick(g);
        rst = 1'b0;
    endtask

    // Monitor: pops on every response handshake and checks that a stalled response holds still.
    initial begin
        rsp_t        r;
        bit          stall_prev = 1'b0;
        logic [1:0]  prev_id = '0;
        logic [31:0] prev_sum = '0;
        logic        prev_cout = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && bus.rsp_valid) begin
                if (stall_prev) begin
                    check("stall_id",   64'(bus.rsp_id),   64'(prev_id));
                    check("stall_sum",  64'(bus.rsp_sum),  64'(prev_sum));
                    check("stall_cout", 64'(bus.rsp_cout), 64'(prev_cout));
                end
                if (bus.rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_rsp", 64'(bus.rsp_valid), 64'(0));
                    end else begin
                        r = exp_q.pop_front();
                        check("sb_id",   64'(bus.rsp_id),   64'(r.id));
                        check("sb_sum",  64'(bus.rsp_sum),  64'(r.sum));
                        check("sb_cout", 64'(bus.rsp_cout), 64'(r.cout));
                    end
                end
            end
            stall_prev = !rst && bus.rsp_valid && !bus.rsp_ready;
            prev_id    = bus.rsp_id;
            prev_sum   = bus.rsp_sum;
            prev_cout  = bus.rsp_cout;
        end
    end

    initial begin
        int g;
        int seq[6];
        int rr_exp[6];
        int n;
        rr_exp = '{0, 1, 2, 3, 0, 1};
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_cin = '0;
        bus.rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset();
        checkOutput("reset", 1'b0, 0, 32'h0, 1'b0);

        // Single request and the two carry boundaries.
        bus.rsp_ready = 1'b1;
        applyStimulus(0, 32'h0000_0005, 32'h0000_0003, 1'b1);
        tick(g);
        check("single_grant", 64'(g), 64'(0));
        checkOutput("single", 1'b1, 0, 32'h0000_0009, 1'b0);
        applyStimulus(1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        tick(g);
        checkOutput("carry_ones", 1'b1, 1, 32'h0000_0000, 1'b1);
        applyStimulus(2, 32'h8000_0000, 32'h8000_0000, 1'b0);
        tick(g);
        checkOutput("carry_msb", 1'b1, 2, 32'h0000_0000, 1'b1);
        tick(g);

        // Round-robin with every requester continuously valid.
        do_reset();
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) applyStimulus(i, $urandom(), $urandom(), 1'($urandom()));
        for (int i = 0; i < 6; i++) begin
            tick(g);
            seq[i] = g;
            if (g >= 0) applyStimulus(g, $urandom(), $urandom(), 1'($urandom()));
        end
        for (int i = 0; i < 6; i++) check("rr_order", 64'(seq[i]), 64'(rr_exp[i]));
        bus.req_valid = '0;
        tick(g);

        // Backpressure: response pending, req 2 waiting, then same-edge drain and accept.
        do_reset();
        bus.rsp_ready = 1'b1;
        applyStimulus(0, 32'd7, 32'd8, 1'b0);
        tick(g);
        bus.rsp_ready = 1'b0;
        applyStimulus(2, 32'd100, 32'd23, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick(g);
            check("bp_no_grant", 64'(g), 64'(-1));
        end
        checkOutput("bp_hold", 1'b1, 0, 32'd15, 1'b0);
        bus.rsp_ready = 1'b1;
        tick(g);
        check("bp_grant", 64'(g), 64'(2));
        checkOutput("bp_after", 1'b1, 2, 32'd123, 1'b0);
        tick(g);

        // Pointer skip from ptr=1 with only requesters 0 and 3 valid.
        do_reset();
        bus.rsp_ready = 1'b1;
        applyStimulus(0, 32'd1, 32'd1, 1'b0);
        tick(g);
        applyStimulus(0, 32'd2, 32'd2, 1'b0);
        applyStimulus(3, 32'd3, 32'd3, 1'b1);
        tick(g);
        check("skip_first", 64'(g), 64'(3));
        tick(g);
        check("skip_second", 64'(g), 64'(0));
        applyStimulus(0, 32'd4, 32'd4, 1'b0);
        applyStimulus(1, 32'd5, 32'd5, 1'b0);
        applyStimulus(2, 32'd6, 32'd6, 1'b0);
        tick(g);
        check("skip_ptr1", 64'(g), 64'(1));
        bus.req_valid = '0;
        tick(g);

        // Reset while a response is pending and requester 1 is waiting.
        do_reset();
        bus.rsp_ready = 1'b0;
        applyStimulus(0, 32'd9, 32'd9, 1'b0);
        tick(g);
        applyStimulus(1, 32'd10, 32'd11, 1'b1);
        rst = 1'b1;
        tick(g);
        check("rst_no_grant", 64'(g), 64'(-1));
        rst = 1'b0;
        checkOutput("rst_mid", 1'b0, 0, 32'h0, 1'b0);
        tick(g);
        check("rst_then_grant", 64'(g), 64'(1));
        checkOutput("rst_then", 1'b1, 1, 32'd22, 1'b0);
        bus.rsp_ready = 1'b1;
        tick(g);

        // Randomized traffic with random backpressure.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!bus.req_valid[i] && $urandom_range(0, 2) == 0)
                    applyStimulus(i, rand_op(), rand_op(), 1'($urandom()));
            end
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            tick(g);
        end

        bus.rsp_ready = 1'b1;
        n = 0;
        while (n < 40 && (exp_q.size() != 0 || bus.req_valid != '0 || model_full)) begin
            tick(g);
            n++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
